// File: rtl/axis_bist_checker_if.sv
// Stream port between the FIFO output demux and the BIST checker.
// A beat transfers on a rising bus_clk edge where i_tvalid & i_tready are both high; i_tvalid never waits on i_tready.
interface axis_bist_checker_if #(
    parameter int DWIDTH = 64
);
    logic [DWIDTH-1:0] i_tdata;
    logic              i_tlast;
    logic              i_tvalid;
    logic              i_tready;

    modport master (output i_tdata, output i_tlast, output i_tvalid, input i_tready);
    modport slave  (input i_tdata, input i_tlast, input i_tvalid, output i_tready);
endinterface

// File: rtl/axis_bist_checker.sv
// Receive-side BIST checker: regenerates constant/ramp payload, checks data and framing, reports status.
// Define AXIS_BIST_CHK_STATS_EN to build the xfer_cnt/cyc_cnt throughput counters (tied to 0 otherwise).
module axis_bist_checker #(
    parameter int DWIDTH = 64,
    parameter int CNT_W  = 32
) (
    input  logic              bus_clk,
    input  logic              bus_rst_n,
    axis_bist_checker_if.slave axis,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              cfg_ramp,
    input  logic              cfg_cont,
    input  logic [31:0]       cfg_pattern,
    input  logic [12:0]       cfg_pkt_bytes,
    input  logic [17:0]       cfg_num_pkts,
    output logic              running,
    output logic              done,
    output logic [1:0]        error,
    output logic [CNT_W-1:0]  xfer_cnt,
    output logic [CNT_W-1:0]  cyc_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t            state;
    logic              tready_q;
    logic              ramp_q;
    logic              cont_q;
    logic [31:0]       pat_q;
    logic [9:0]        last_line_q;
    logic [17:0]       num_pkts_q;
    logic [9:0]        line_cnt;
    logic [17:0]       pkt_cnt;
    logic [DWIDTH-1:0] ramp_val;
    logic              stop_pend;

    logic [12:0]       cfg_lines;
    logic [9:0]        last_line_d;
    logic [DWIDTH-1:0] exp_data;
    logic              accept;
    logic              at_last;
    logic              data_err;
    logic              frame_err;
    logic              wrap;
    logic              pkts_done;
    logic              stop_done;
    logic              run_end;
    logic              start_go;

    assign axis.i_tready = tready_q;

    // A zero-line packet length is treated as a single-line packet.
    assign cfg_lines   = cfg_pkt_bytes >> 3;
    assign last_line_d = (cfg_lines == '0) ? '0 : 10'(cfg_lines - 13'd1);

    assign accept    = axis.i_tvalid & tready_q;
    assign exp_data  = ramp_q ? ramp_val : {pat_q, pat_q};
    assign at_last   = (line_cnt == last_line_q);
    assign data_err  = accept && (axis.i_tdata != exp_data);
    assign frame_err = accept && (axis.i_tlast != at_last);
    assign wrap      = accept && at_last;
    assign pkts_done = wrap && !cont_q && ((pkt_cnt + 18'd1) == num_pkts_q);
    // Stop closes a continuous run at the packet boundary: on the last line, or at once when idle between packets.
    assign stop_done = cont_q && (stop || stop_pend) && (wrap || (!accept && line_cnt == '0));
    assign run_end   = (!cont_q && num_pkts_q == '0) || data_err || frame_err || pkts_done || stop_done;
    assign start_go  = start && (state != ST_RUN);

    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            state       <= ST_IDLE;
            running     <= 1'b0;
            done        <= 1'b0;
            error       <= 2'b00;
            tready_q    <= 1'b0;
            ramp_q      <= 1'b0;
            cont_q      <= 1'b0;
            pat_q       <= '0;
            last_line_q <= '0;
            num_pkts_q  <= '0;
            line_cnt    <= '0;
            pkt_cnt     <= '0;
            ramp_val    <= '0;
            stop_pend   <= 1'b0;
        end else if (clear) begin
            state     <= ST_IDLE;
            running   <= 1'b0;
            done      <= 1'b0;
            error     <= 2'b00;
            tready_q  <= 1'b0;
            stop_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_go) begin
                        state       <= ST_RUN;
                        running     <= 1'b1;
                        done        <= 1'b0;
                        error       <= 2'b00;
                        // An empty non-continuous run never opens the stream.
                        tready_q    <= !(cfg_num_pkts == '0 && !cfg_cont);
                        ramp_q      <= cfg_ramp;
                        cont_q      <= cfg_cont;
                        pat_q       <= cfg_pattern;
                        last_line_q <= last_line_d;
                        num_pkts_q  <= cfg_num_pkts;
                        line_cnt    <= '0;
                        pkt_cnt     <= '0;
                        ramp_val    <= {{(DWIDTH-32){1'b0}}, cfg_pattern};
                        stop_pend   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        ramp_val <= ramp_val + 1'b1;
                        error    <= error | {frame_err, data_err};
                        line_cnt <= at_last ? '0 : line_cnt + 10'd1;
                        if (at_last) pkt_cnt <= pkt_cnt + 18'd1;
                    end
                    if (stop && cont_q) stop_pend <= 1'b1;
                    if (run_end) begin
                        state    <= ST_DONE;
                        running  <= 1'b0;
                        done     <= 1'b1;
                        tready_q <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef AXIS_BIST_CHK_STATS_EN
    always_ff @(posedge bus_clk) begin
        if (!bus_rst_n) begin
            xfer_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (start_go && !clear) begin
            xfer_cnt <= '0;
            cyc_cnt  <= '0;
        end else begin
            if (state == ST_RUN && cyc_cnt != {CNT_W{1'b1}}) cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (accept && xfer_cnt != {CNT_W{1'b1}}) xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`else
    assign xfer_cnt = '0;
    assign cyc_cnt  = '0;
`endif
endmodule

// File: tb/tb_axis_bist_checker.sv
// Bench for axis_bist_checker: table of whole-run vectors plus hand-written stop/clear/reset sequences.
module tb_axis_bist_checker;
    localparam int CNT_W = 32;
`ifdef AXIS_BIST_CHK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             bus_clk = 1'b0;
    logic             bus_rst_n = 1'b0;
    logic             start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic             cfg_ramp = 1'b0, cfg_cont = 1'b0;
    logic [31:0]      cfg_pattern = '0;
    logic [12:0]      cfg_pkt_bytes = '0;
    logic [17:0]      cfg_num_pkts = '0;
    logic             running, done;
    logic [1:0]       error;
    logic [CNT_W-1:0] xfer_cnt, cyc_cnt;

    axis_bist_checker_if #(.DWIDTH(64)) axis ();

    axis_bist_checker #(.DWIDTH(64), .CNT_W(CNT_W)) u_dut (
        .bus_clk       (bus_clk),
        .bus_rst_n     (bus_rst_n),
        .axis          (axis),
        .start         (start),
        .stop          (stop),
        .clear         (clear),
        .cfg_ramp      (cfg_ramp),
        .cfg_cont      (cfg_cont),
        .cfg_pattern   (cfg_pattern),
        .cfg_pkt_bytes (cfg_pkt_bytes),
        .cfg_num_pkts  (cfg_num_pkts),
        .running       (running),
        .done          (done),
        .error         (error),
        .xfer_cnt      (xfer_cnt),
        .cyc_cnt       (cyc_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    typedef struct {
        logic        ramp;
        logic        cont;
        logic [31:0] pattern;
        logic [12:0] pkt_bytes;
        logic [17:0] num_pkts;
        int          err_beat;
        int          tlast_beat;
        logic [1:0]  exp_error;
        int          exp_beats;
    } vec_t;

    vec_t        vecs[8];
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One clock: drive at negedge, let the edge happen, return #1 after it with pulses dropped.
    task automatic cyc_drive(input logic valid, input logic [63:0] d, input logic last,
                             input logic st, input logic stp, input logic clr, output logic acc);
        @(negedge bus_clk);
        axis.i_tvalid = valid;
        axis.i_tdata  = d;
        axis.i_tlast  = last;
        start = st;
        stop  = stp;
        clear = clr;
        acc   = valid && axis.i_tready;
        @(posedge bus_clk);
        #1;
        start = 1'b0;
        stop  = 1'b0;
        clear = 1'b0;
    endtask

    task automatic set_cfg(input logic ramp, input logic cont, input logic [31:0] pat,
                           input logic [12:0] bytes, input logic [17:0] npk);
        cfg_ramp = ramp;
        cfg_cont = cont;
        cfg_pattern = pat;
        cfg_pkt_bytes = bytes;
        cfg_num_pkts = npk;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          n, cyc, budget, lines;
        logic [63:0] d;
        logic        last, acc;
        logic [33:0] e;
        lines = int'(v.pkt_bytes >> 3);
        if (lines == 0) lines = 1;
        set_cfg(v.ramp, v.cont, v.pattern, v.pkt_bytes, v.num_pkts);
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        exp_q.push_back({v.exp_error, 32'(v.exp_beats)});
        // Scramble cfg after start so a design that fails to latch it is caught.
        set_cfg(~v.ramp, v.cont, ~v.pattern, 13'd8, 18'd1);
        n = 0;
        cyc = 0;
        budget = v.exp_beats * 4 + 40;
        while (n < v.exp_beats && cyc < budget) begin
            d = v.ramp ? ({32'h0, v.pattern} + 64'(n)) : {v.pattern, v.pattern};
            if (n == v.err_beat) d[63] = ~d[63];
            last = ((n % lines) == lines - 1);
            if (n == v.tlast_beat) last = ~last;
            cyc_drive($urandom_range(0, 3) != 0, d, last, 1'b0, 1'b0, 1'b0, acc);
            cyc++;
            if (acc) n++;
        end
        axis.i_tvalid = 1'b0;
        e = exp_q.pop_front();
        check($sformatf("v%0d_beats", idx), 64'(n), 64'(v.exp_beats));
        check($sformatf("v%0d_done", idx), {63'h0, done}, 64'h1);
        check($sformatf("v%0d_running", idx), {63'h0, running}, 64'h0);
        check($sformatf("v%0d_tready", idx), {63'h0, axis.i_tready}, 64'h0);
        check($sformatf("v%0d_error", idx), {62'h0, error}, {62'h0, e[33:32]});
        check($sformatf("v%0d_xfer", idx), 64'(xfer_cnt), STATS ? 64'(e[31:0]) : 64'h0);
        check($sformatf("v%0d_cyc", idx), 64'(cyc_cnt), STATS ? 64'(cyc) : 64'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        logic [63:0] d;
        axis.i_tvalid = 1'b0;
        axis.i_tdata  = '0;
        axis.i_tlast  = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 32'h01234567, 13'd40,   18'd10, -1,  -1, 2'b00, 50};
        vecs[1] = '{1'b0, 1'b0, 32'h01234567, 13'd40,   18'd10,  7,  -1, 2'b01, 8};
        vecs[2] = '{1'b1, 1'b0, 32'h0ABCDEF0, 13'd1000, 18'd3,  -1,  -1, 2'b00, 375};
        vecs[3] = '{1'b1, 1'b0, 32'h0ABCDEF0, 13'd1000, 18'd3,  -1,  99, 2'b10, 100};
        vecs[4] = '{1'b0, 1'b0, 32'hCAFEF00D, 13'd5,    18'd4,  -1,  -1, 2'b00, 4};
        vecs[5] = '{1'b1, 1'b0, 32'h12345678, 13'd16,   18'd3,  -1,  -1, 2'b00, 6};
        vecs[6] = '{1'b0, 1'b0, 32'h5A5A0F0F, 13'd44,   18'd2,   2,   2, 2'b11, 3};
        vecs[7] = '{1'b0, 1'b0, 32'hDEADBEEF, 13'd24,   18'd2,  -1,   2, 2'b10, 3};

        // Reset state
        repeat (3) @(posedge bus_clk);
        #1;
        check("rst_running", {63'h0, running}, 64'h0);
        check("rst_done", {63'h0, done}, 64'h0);
        check("rst_error", {62'h0, error}, 64'h0);
        check("rst_tready", {63'h0, axis.i_tready}, 64'h0);
        check("rst_xfer", 64'(xfer_cnt), 64'h0);
        check("rst_cyc", 64'(cyc_cnt), 64'h0);
        bus_rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Clear from an errored DONE
        cyc_drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        check("clr_done", {63'h0, done}, 64'h0);
        check("clr_error", {62'h0, error}, 64'h0);

        // Zero packets: no beats, done two cycles after start
        set_cfg(1'b0, 1'b0, 32'h11111111, 13'd40, 18'd0);
        cyc_drive(1'b1, 64'h1111111111111111, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        check("np0_c1_done", {63'h0, done}, 64'h0);
        check("np0_c1_tready", {63'h0, axis.i_tready}, 64'h0);
        cyc_drive(1'b1, 64'h1111111111111111, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("np0_c2_acc", {63'h0, acc}, 64'h0);
        check("np0_c2_done", {63'h0, done}, 64'h1);
        check("np0_c2_error", {62'h0, error}, 64'h0);
        check("np0_c2_xfer", 64'(xfer_cnt), 64'h0);

        // Continuous run, stop on beat 10 of a 32-line packet
        set_cfg(1'b0, 1'b1, 32'hA5A5C3C3, 13'd256, 18'd1);
        d = 64'hA5A5C3C3A5A5C3C3;
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        for (int n = 0; n < 31; n++) cyc_drive(1'b1, d, 1'b0, 1'b0, n == 9, 1'b0, acc);
        check("stop_hold_running", {63'h0, running}, 64'h1);
        check("stop_hold_done", {63'h0, done}, 64'h0);
        cyc_drive(1'b1, d, 1'b1, 1'b0, 1'b0, 1'b0, acc);
        check("stop_end_done", {63'h0, done}, 64'h1);
        check("stop_end_running", {63'h0, running}, 64'h0);
        check("stop_end_error", {62'h0, error}, 64'h0);
        check("stop_end_xfer", 64'(xfer_cnt), STATS ? 64'd32 : 64'h0);
        check("stop_end_cyc", 64'(cyc_cnt), STATS ? 64'd32 : 64'h0);

        // Stop between packets ends the run at once
        set_cfg(1'b0, 1'b1, 32'h00FF00FF, 13'd16, 18'd1);
        d = 64'h00FF00FF00FF00FF;
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        for (int n = 0; n < 4; n++) cyc_drive(1'b1, d, n[0], 1'b0, 1'b0, 1'b0, acc);
        check("gap_stop_running", {63'h0, running}, 64'h1);
        cyc_drive(1'b0, d, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check("gap_stop_done", {63'h0, done}, 64'h1);
        check("gap_stop_error", {62'h0, error}, 64'h0);
        check("gap_stop_xfer", 64'(xfer_cnt), STATS ? 64'd4 : 64'h0);

        // Clear and start together during RUN: clear wins
        set_cfg(1'b1, 1'b1, 32'h00000100, 13'd64, 18'd1);
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        for (int n = 0; n < 3; n++) cyc_drive(1'b1, 64'h100 + 64'(n), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b1, acc);
        check("clrst_running", {63'h0, running}, 64'h0);
        check("clrst_done", {63'h0, done}, 64'h0);
        check("clrst_error", {62'h0, error}, 64'h0);
        check("clrst_tready", {63'h0, axis.i_tready}, 64'h0);

        // Reset mid-run
        cyc_drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        for (int n = 0; n < 3; n++) cyc_drive(1'b1, 64'h100 + 64'(n), 1'b0, 1'b0, 1'b0, 1'b0, acc);
        check("mid_running", {63'h0, running}, 64'h1);
        @(negedge bus_clk);
        bus_rst_n = 1'b0;
        @(posedge bus_clk);
        #1;
        check("mid_rst_running", {63'h0, running}, 64'h0);
        check("mid_rst_done", {63'h0, done}, 64'h0);
        check("mid_rst_error", {62'h0, error}, 64'h0);
        check("mid_rst_tready", {63'h0, axis.i_tready}, 64'h0);
        check("mid_rst_xfer", 64'(xfer_cnt), 64'h0);
        check("mid_rst_cyc", 64'(cyc_cnt), 64'h0);
        bus_rst_n = 1'b1;
        axis.i_tvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
